ahb_sram_subordinate: RTL and testbench

AHB-Lite subordinate (responder) fronting a single-port on-chip SRAM of 64 KB by default, serving the instruction/data initiator of the RV32IM core. It decodes NONSEQ/SEQ transfers and supports byte, halfword and word accesses with per-lane write enables. It inserts a configurable number of wait states and returns the two-cycle AHB-Lite ERROR response for illegal accesses.

---
 rtl/ahb_sram_subordinate_pkg.sv | 49 ++++
 rtl/ahb_sram_subordinate_if.sv | 26 ++
 rtl/ahb_byte_lane_decoder.sv | 30 +++
 rtl/ahb_sram_subordinate.sv | 161 ++++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_subordinate_pkg.sv
// Shared types and constants for the AHB-Lite SRAM subordinate.
// Build option: define AHB_SRAM_ERR_EN to enable illegal-access detection
// and the two-cycle ERROR response.
package ahb_sram_subordinate_pkg;

    // Default SRAM depth in 32-bit words (64 KB).
    localparam int MEM_DEPTH = 16384;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } ahb_trans_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } ahb_resp_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'b000,
        SIZE_HALF = 3'b001,
        SIZE_WORD = 3'b010
    } ahb_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_sub_state_e;

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_en);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle between one initiator and the SRAM subordinate.
// Build option AHB_SRAM_ERR_EN does not change this interface.
interface ahb_sram_subordinate_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_byte_lane_decoder.sv
// Combinational HSIZE/HADDR[1:0] decode into a byte-lane write mask.
// The mask always uses the size-aligned address, so a misaligned access in a
// build without AHB_SRAM_ERR_EN simply ignores the low address bits.
module ahb_byte_lane_decoder
    import ahb_sram_subordinate_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] byte_en,
    output logic       misalign,
    output logic       size_bad
);

    // Lane mask plus alignment and size legality for the current address phase.
    always_comb begin
        byte_en  = 4'b1111;
        misalign = 1'b0;
        size_bad = 1'b0;
        case (size)
            SIZE_BYTE: byte_en = 4'b0001 << addr_lo;
            SIZE_HALF: begin
                byte_en  = 4'b0011 << {addr_lo[1], 1'b0};
                misalign = addr_lo[0];
            end
            SIZE_WORD: misalign = |addr_lo;
            default:   size_bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a single-port SRAM with optional wait
// states. MEM_WORDS must be a power of two; out-of-range addresses wrap.
// Build option: define AHB_SRAM_ERR_EN to flag misaligned, oversized or
// out-of-range transfers with the two-cycle ERROR response.
module ahb_sram_subordinate
    import ahb_sram_subordinate_pkg::*;
#(
    parameter int MEM_WORDS   = MEM_DEPTH,
    parameter int WAIT_STATES = 0
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    ahb_sram_subordinate_if.slave  bus
);

    localparam int          ADDR_W    = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [1:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    logic [31:0] mem [MEM_WORDS];

    ahb_sub_state_e    state;
    logic [1:0]        wait_cnt;
    logic [ADDR_W-1:0] idx_q;
    logic              write_q;
    logic [3:0]        be_q;
    logic [31:0]       rdata_q;
    logic              hreadyout_q;
    logic              hresp_q;

    logic [3:0]        req_be;
    logic              req_misalign;
    logic              req_size_bad;
    logic              req_illegal;
    logic [ADDR_W-1:0] req_idx;
    logic              accept;
    logic              commit;
    logic              go_data_now;
    logic              wait_done;
    logic              load_read;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       rd_word;
    logic              unused_bits;

    ahb_byte_lane_decoder u_lane_dec (
        .size     (bus.HSIZE),
        .addr_lo  (bus.HADDR[1:0]),
        .byte_en  (req_be),
        .misalign (req_misalign),
        .size_bad (req_size_bad)
    );

    assign req_idx = bus.HADDR[ADDR_W+1:2];

    // A new address phase is only taken while this subordinate is not stalling.
    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1]
                  & (state != ST_WAIT) & (state != ST_ERR1);

`ifdef AHB_SRAM_ERR_EN
    assign req_illegal = req_size_bad | req_misalign | ({1'b0, bus.HADDR} >= MEM_BYTES);
    assign unused_bits = bus.HTRANS[0];
`else
    assign req_illegal = 1'b0;
    assign unused_bits = ^{bus.HTRANS[0], req_size_bad, req_misalign,
                           bus.HADDR[31:ADDR_W+2], hresp_q};
`endif

    assign commit      = (state == ST_DATA) && write_q;
    assign go_data_now = accept && !req_illegal && (WAIT_STATES == 0);
    assign wait_done   = (state == ST_WAIT) && (wait_cnt == 2'd0);
    assign load_read   = (go_data_now && !bus.HWRITE) || (wait_done && !write_q);

    // Read word for the data phase about to start, forwarding a write that commits on the same edge.
    always_comb begin
        rd_idx  = wait_done ? idx_q : req_idx;
        rd_word = mem[rd_idx];
        if (commit && (idx_q == rd_idx)) begin
            rd_word = merge_lanes(rd_word, bus.HWDATA, be_q);
        end
    end

    // Transfer FSM with registered HREADYOUT, HRESP and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= 2'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            be_q        <= 4'b0000;
            rdata_q     <= 32'h0;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
        end else begin
            rdata_q <= load_read ? rd_word : 32'h0;
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state       <= ST_DATA;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
`ifdef AHB_SRAM_ERR_EN
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= RESP_ERROR;
                end
`endif
                default: begin
                    if (accept) begin
                        idx_q   <= req_idx;
                        write_q <= bus.HWRITE;
                        be_q    <= req_be;
                        if (req_illegal) begin
                            state       <= ST_ERR1;
                            write_q     <= 1'b0;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= RESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state       <= ST_WAIT;
                            wait_cnt    <= WAIT_LOAD;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= RESP_OKAY;
                        end else begin
                            state       <= ST_DATA;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= RESP_OKAY;
                        end
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    // Commit the enabled write lanes at the closing edge of a write data phase; contents are never reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign bus.HRDATA    = rdata_q;
    assign bus.HREADYOUT = hreadyout_q;
`ifdef AHB_SRAM_ERR_EN
    assign bus.HRESP     = hresp_q;
`else
    assign bus.HRESP     = RESP_OKAY;
`endif

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench for ahb_sram_subordinate: one instance with no wait states,
// one with two. Error-path vectors follow AHB_SRAM_ERR_EN.
module tb_ahb_sram_subordinate;
    import ahb_sram_subordinate_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          tgt = 0;
    logic [1:0]  htrans = TRANS_IDLE;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = SIZE_WORD;
    logic [31:0] haddr = 32'h0;
    logic [31:0] hwdata = 32'h0;
    logic        hready_gate = 1'b1;

    int checks = 0;
    int failures = 0;

    ahb_sram_subordinate_if bus0 ();
    ahb_sram_subordinate_if bus2 ();

    assign bus0.HSEL   = (tgt == 1);
    assign bus0.HADDR  = haddr;
    assign bus0.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT & hready_gate;

    assign bus2.HSEL   = (tgt == 2);
    assign bus2.HADDR  = haddr;
    assign bus2.HTRANS = htrans;
    assign bus2.HWRITE = hwrite;
    assign bus2.HSIZE  = hsize;
    assign bus2.HWDATA = hwdata;
    assign bus2.HREADY = bus2.HREADYOUT & hready_gate;

    ahb_sram_subordinate #(.MEM_WORDS(16384), .WAIT_STATES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    ahb_sram_subordinate #(.MEM_WORDS(16384), .WAIT_STATES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    // Drive one address phase (plus the data-phase HWDATA of the previous transfer) and step one clock.
    task automatic applyStimulus(input int target, input logic [1:0] trans, input logic write,
                                 input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        tgt    = target;
        htrans = trans;
        hwrite = write;
        hsize  = size;
        haddr  = addr;
        hwdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Single-cycle read on dut0 followed by an idle cycle; returns the data-phase HRDATA.
    task automatic readWord0(input logic [31:0] addr, input logic [31:0] expected, input string tag);
        applyStimulus(1, TRANS_NONSEQ, 1'b0, SIZE_WORD, addr, 32'h0);
        checkOutput(tag, bus0.HRDATA, expected);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h0);
    endtask

`ifdef AHB_SRAM_ERR_EN
    logic [31:0] err_addr [4] = '{32'h0000_0002, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    logic [2:0]  err_size [4] = '{SIZE_WORD, SIZE_WORD, SIZE_HALF, 3'b011};
`endif

    initial begin
        int low_cycles;

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset hreadyout", {31'h0, bus0.HREADYOUT}, 32'h1);
        checkOutput("reset hresp", {31'h0, bus0.HRESP}, 32'h0);
        checkOutput("reset hrdata", bus0.HRDATA, 32'h0);
        checkOutput("reset hreadyout ws2", {31'h0, bus2.HREADYOUT}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] word write then back-to-back read");
        applyStimulus(1, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h10, 32'h0);
        checkOutput("write dphase hreadyout", {31'h0, bus0.HREADYOUT}, 32'h1);
        applyStimulus(1, TRANS_NONSEQ, 1'b0, SIZE_WORD, 32'h10, 32'hDEADBEEF);
        checkOutput("raw hrdata", bus0.HRDATA, 32'hDEADBEEF);
        checkOutput("raw hresp", {31'h0, bus0.HRESP}, 32'h0);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        checkOutput("idle hrdata zero", bus0.HRDATA, 32'h0);

        $display("[TB] byte and half lanes");
        applyStimulus(1, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h20, 32'h0);
        applyStimulus(1, TRANS_SEQ,    1'b1, SIZE_BYTE, 32'h23, 32'h11223344);
        applyStimulus(1, TRANS_NONSEQ, 1'b1, SIZE_HALF, 32'h20, 32'hAAAAAAAA);
        applyStimulus(1, TRANS_NONSEQ, 1'b0, SIZE_WORD, 32'h20, 32'hBEEFBEEF);
        checkOutput("lanes hrdata", bus0.HRDATA, 32'hAA22BEEF);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        readWord0(32'h10, 32'hDEADBEEF, "lanes neighbour");

        $display("[TB] idle, busy and deselect");
        applyStimulus(1, TRANS_IDLE, 1'b1, SIZE_WORD, 32'h10, 32'h0);
        checkOutput("idle hreadyout", {31'h0, bus0.HREADYOUT}, 32'h1);
        applyStimulus(1, TRANS_BUSY, 1'b1, SIZE_WORD, 32'h10, 32'h11111111);
        checkOutput("busy hresp", {31'h0, bus0.HRESP}, 32'h0);
        applyStimulus(0, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h10, 32'h22222222);
        checkOutput("desel hreadyout", {31'h0, bus0.HREADYOUT}, 32'h1);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h33333333);
        readWord0(32'h10, 32'hDEADBEEF, "no-write hrdata");

        $display("[TB] bus stalled by another subordinate");
        hready_gate = 1'b0;
        applyStimulus(1, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h10, 32'h0);
        hready_gate = 1'b1;
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h12345678);
        checkOutput("stall hreadyout", {31'h0, bus0.HREADYOUT}, 32'h1);
        readWord0(32'h10, 32'hDEADBEEF, "stall no-write");

        $display("[TB] two wait states");
        applyStimulus(2, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h40, 32'h0);
        low_cycles = 0;
        while (bus2.HREADYOUT == 1'b0 && low_cycles < 10) begin
            low_cycles++;
            applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'hCAFEF00D);
        end
        checkOutput("ws write low cycles", low_cycles, 2);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'hCAFEF00D);
        applyStimulus(2, TRANS_NONSEQ, 1'b0, SIZE_WORD, 32'h40, 32'h0);
        checkOutput("ws wait hrdata", bus2.HRDATA, 32'h0);
        low_cycles = 0;
        while (bus2.HREADYOUT == 1'b0 && low_cycles < 10) begin
            low_cycles++;
            applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        end
        checkOutput("ws read low cycles", low_cycles, 2);
        checkOutput("ws read hrdata", bus2.HRDATA, 32'hCAFEF00D);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h0);
        checkOutput("ws after hrdata", bus2.HRDATA, 32'h0);

`ifdef AHB_SRAM_ERR_EN
        $display("[TB] error responses");
        applyStimulus(1, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h0, 32'h0);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h55AA55AA);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, TRANS_NONSEQ, 1'b1, err_size[i], err_addr[i], 32'h0);
            checkOutput($sformatf("err%0d err1 hreadyout", i), {31'h0, bus0.HREADYOUT}, 32'h0);
            checkOutput($sformatf("err%0d err1 hresp", i), {31'h0, bus0.HRESP}, 32'h1);
            applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'hFFFFFFFF);
            checkOutput($sformatf("err%0d err2 hreadyout", i), {31'h0, bus0.HREADYOUT}, 32'h1);
            checkOutput($sformatf("err%0d err2 hresp", i), {31'h0, bus0.HRESP}, 32'h1);
            applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'hFFFFFFFF);
            checkOutput($sformatf("err%0d after hresp", i), {31'h0, bus0.HRESP}, 32'h0);
        end
        readWord0(32'h0, 32'h55AA55AA, "err word0 unchanged");
`else
        $display("[TB] alignment, wrap and oversize without error logic");
        applyStimulus(1, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h2, 32'h0);
        checkOutput("align hresp", {31'h0, bus0.HRESP}, 32'h0);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h01020304);
        readWord0(32'h0, 32'h01020304, "align hrdata");
        applyStimulus(1, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h0001_0004, 32'h0);
        checkOutput("wrap hreadyout", {31'h0, bus0.HREADYOUT}, 32'h1);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h0A0B0C0D);
        readWord0(32'h4, 32'h0A0B0C0D, "wrap hrdata");
        applyStimulus(1, TRANS_NONSEQ, 1'b1, 3'b011, 32'h8, 32'h0);
        applyStimulus(0, TRANS_IDLE, 1'b0, SIZE_WORD, 32'h0, 32'h99887766);
        readWord0(32'h8, 32'h99887766, "oversize hrdata");
`endif

        $display("[TB] reset aborts an in-flight write");
        applyStimulus(1, TRANS_NONSEQ, 1'b1, SIZE_WORD, 32'h10, 32'h0);
        tgt    = 0;
        htrans = TRANS_IDLE;
        hwdata = 32'h77777777;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort hreadyout", {31'h0, bus0.HREADYOUT}, 32'h1);
        checkOutput("abort hrdata", bus0.HRDATA, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        readWord0(32'h10, 32'hDEADBEEF, "abort no-commit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
